// File: rtl/special_result_stage_div.sv
// rtl/special_result_stage_div.sv - divider special-case result select with 2-entry output FIFO
module special_result_stage_div #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [E+M:0]                X,
    input  logic [E+M:0]                Y,
    input  logic [$clog2(special_case)-1:0] X_special_case,
    input  logic [$clog2(special_case)-1:0] Y_special_case,
    input  logic                        X_one,
    input  logic [E+M:0]                Q_norm,
    output logic [E+M:0]                Z,
    output logic                        Z_valid,
    input  logic                        Z_ready,
    output logic                        is_special,
    output logic                        invalid_op,
    output logic                        div_by_zero,
    output logic [15:0]                 spec_count
);
    localparam int W  = E + M + 1;
    localparam int CW = $clog2(special_case);

    typedef struct packed {
        logic [W-1:0] z;
        logic         sp;
        logic         inv;
        logic         dbz;
    } entry_t;

    entry_t      res_d;
    entry_t      mem_q [2];
    entry_t      head;
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic [15:0] spec_count_q;
    logic        push, pop, s;
    logic        x_inf, x_zero, y_inf, y_zero, y_one;

    // Codes outside 1..6 never match any class below, so they behave as "none".
    assign x_inf  = (X_special_case == CW'(1)) || (X_special_case == CW'(2));
    assign x_zero = (X_special_case == CW'(3)) || (X_special_case == CW'(4));
    assign y_inf  = (Y_special_case == CW'(1)) || (Y_special_case == CW'(2));
    assign y_zero = (Y_special_case == CW'(3)) || (Y_special_case == CW'(4));
    assign y_one  = (Y_special_case == CW'(5)) || (Y_special_case == CW'(6));
    assign s      = X[W-1] ^ Y[W-1];

    always_comb begin
        res_d = '0;
        if (x_inf && y_inf) begin
            res_d.z   = {s, {(W-1){1'b1}}};
            res_d.sp  = 1'b1;
            res_d.inv = 1'b1;
        end else if (x_zero && y_zero) begin
            res_d.z   = {s, {(W-1){1'b0}}};
            res_d.sp  = 1'b1;
            res_d.inv = 1'b1;
        end else if (y_zero) begin
            res_d.z   = {s, {(W-1){1'b1}}};
            res_d.sp  = 1'b1;
            res_d.dbz = 1'b1;
        end else if (x_inf) begin
            res_d.z   = {s, {(W-1){1'b1}}};
            res_d.sp  = 1'b1;
        end else if (x_zero || y_inf) begin
            res_d.z   = {s, {(W-1){1'b0}}};
            res_d.sp  = 1'b1;
        end else if (y_one) begin
            res_d.z   = {s, X[W-2:0]};
            res_d.sp  = 1'b1;
        end else begin
            res_d.z   = Q_norm;
        end
    end

    assign in_ready = (count_q != 2'd2);
    assign Z_valid  = (count_q != 2'd0);
    assign push     = in_valid && in_ready;
    assign pop      = Z_valid && Z_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            spec_count_q <= 16'd0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            if (push && res_d.sp && (spec_count_q != 16'hFFFF))
                spec_count_q <= spec_count_q + 16'd1;
        end
    end

    // Entry storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= res_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign Z           = Z_valid ? head.z   : '0;
    assign is_special  = Z_valid ? head.sp  : 1'b0;
    assign invalid_op  = Z_valid ? head.inv : 1'b0;
    assign div_by_zero = Z_valid ? head.dbz : 1'b0;
    assign spec_count  = spec_count_q;
endmodule

// File: tb/tb_special_result_stage_div.sv
// tb/tb_special_result_stage_div.sv - self-checking bench for special_result_stage_div
module tb_special_result_stage_div;
    logic        clk = 1'b0;
    logic        rst_l, in_valid, in_ready, X_one, Z_valid, Z_ready;
    logic [31:0] X, Y, Q_norm, Z;
    logic [2:0]  X_special_case, Y_special_case;
    logic        is_special, invalid_op, div_by_zero;
    logic [15:0] spec_count;

    int tests = 0;
    int fails = 0;

    special_result_stage_div #(.M(23), .E(8), .special_case(7)) dut (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .X_special_case(X_special_case), .Y_special_case(Y_special_case),
        .X_one(X_one), .Q_norm(Q_norm), .Z(Z), .Z_valid(Z_valid), .Z_ready(Z_ready),
        .is_special(is_special), .invalid_op(invalid_op), .div_by_zero(div_by_zero),
        .spec_count(spec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x, y, qn;
        logic [2:0]  xc, yc;
        logic        xone;
        logic [31:0] ez;
        logic        esp, einv, edbz;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic        sp, inv, dbz;
    } res_t;

    typedef enum int {C_NONE, C_INF, C_ZERO, C_ONE} cls_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cls_t classify(input logic [2:0] code);
        case (int'(code))
            1, 2:    return C_INF;
            3, 4:    return C_ZERO;
            5, 6:    return C_ONE;
            default: return C_NONE;
        endcase
    endfunction

    // Reference: IEEE-style division of special classes, sign = xor of operand signs.
    function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                       input logic [2:0] xc, input logic [2:0] yc,
                                       input logic [31:0] qn);
        res_t  r;
        cls_t  a = classify(xc);
        cls_t  b = classify(yc);
        logic  sg = x[31] ^ y[31];
        logic [31:0] inf_v  = sg ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        logic [31:0] zero_v = sg ? 32'h8000_0000 : 32'h0000_0000;
        r = '{z: qn, sp: 1'b1, inv: 1'b0, dbz: 1'b0};
        if (a == C_INF && b == C_INF)       begin r.z = inf_v;  r.inv = 1'b1; end
        else if (a == C_ZERO && b == C_ZERO) begin r.z = zero_v; r.inv = 1'b1; end
        else if (b == C_ZERO)               begin r.z = inf_v;  r.dbz = 1'b1; end
        else if (a == C_INF)                r.z = inf_v;
        else if (a == C_ZERO || b == C_INF) r.z = zero_v;
        else if (b == C_ONE)                r.z = {sg, x[30:0]};
        else                                r.sp = 1'b0;
        return r;
    endfunction

    task automatic drive_beat(input logic [31:0] x, input logic [31:0] y, input logic [2:0] xc,
                              input logic [2:0] yc, input logic xone, input logic [31:0] qn);
        in_valid = 1'b1; X = x; Y = y; X_special_case = xc; Y_special_case = yc;
        X_one = xone; Q_norm = qn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0; in_valid = 1'b0; Z_ready = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    vec_t        vt [13];
    res_t        q [$];
    res_t        r;
    logic [31:0] got [$];
    int          spec_m;
    bit          c_sent;

    initial begin
        vt[0]  = '{32'h3FC00000, 32'hC0000000, 32'h0,        3'd0, 3'd6, 1'b0, 32'hBFC00000, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{32'h00000000, 32'h80000000, 32'h0,        3'd3, 3'd4, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{32'h12345678, 32'h80000000, 32'h0,        3'd0, 3'd4, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{32'h40000000, 32'h3F000000, 32'h2468ACE0, 3'd0, 3'd0, 1'b0, 32'h2468ACE0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{32'h7F800000, 32'hFF800000, 32'h0,        3'd1, 3'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{32'hFF800000, 32'h40000000, 32'h0,        3'd2, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{32'h80000000, 32'h40400000, 32'h0,        3'd4, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{32'h40400000, 32'hFF800000, 32'h0,        3'd0, 3'd2, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{32'h7F800000, 32'h00000000, 32'h0,        3'd1, 3'd3, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 3'd5, 3'd0, 1'b1, 32'h3F000000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h12345678, 32'h00000000, 32'h11111111, 3'd7, 3'd7, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'hC1200000, 32'h3F800000, 32'h0,        3'd0, 3'd5, 1'b0, 32'hC1200000, 1'b1, 1'b0, 1'b0};
        vt[12] = '{32'h00000000, 32'h3F800000, 32'h0,        3'd3, 3'd5, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};

        rst_l = 1'b0; in_valid = 1'b0; Z_ready = 1'b0; X = '0; Y = '0; Q_norm = '0;
        X_special_case = '0; Y_special_case = '0; X_one = 1'b0;
        do_reset();
        #1;
        chk("reset_zvalid", Z_valid, 0);
        chk("reset_outs", {Z, is_special, invalid_op, div_by_zero}, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_spec_count", spec_count, 0);

        // Directed vectors, one at a time into an empty FIFO
        spec_m = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            Z_ready = 1'b1;
            drive_beat(vt[i].x, vt[i].y, vt[i].xc, vt[i].yc, vt[i].xone, vt[i].qn);
            @(negedge clk);
            in_valid = 1'b0;
            spec_m += int'(vt[i].esp);
            chk($sformatf("vec%0d_valid", i), Z_valid, 1);
            chk($sformatf("vec%0d_z", i), Z, vt[i].ez);
            chk($sformatf("vec%0d_flags", i), {is_special, invalid_op, div_by_zero},
                {vt[i].esp, vt[i].einv, vt[i].edbz});
            chk($sformatf("vec%0d_spec_count", i), spec_count, spec_m);
        end
        @(negedge clk);
        chk("drain_empty", Z_valid, 0);

        // Backpressure: three beats with Z_ready low
        do_reset();
        Z_ready = 1'b0;
        drive_beat(32'h0, 32'h0, 3'd0, 3'd0, 1'b0, 32'hAAAA0001);
        @(negedge clk);
        drive_beat(32'h0, 32'h0, 3'd0, 3'd0, 1'b0, 32'hAAAA0002);
        @(negedge clk);
        drive_beat(32'h0, 32'h0, 3'd0, 3'd0, 1'b0, 32'hAAAA0003);
        #1;
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_head", Z, 32'hAAAA0001);
        @(negedge clk);
        chk("bp_hold_z", Z, 32'hAAAA0001);
        chk("bp_hold_valid", Z_valid, 1);
        chk("bp_hold_in_ready", in_ready, 0);
        Z_ready = 1'b1;
        c_sent = 1'b0;
        got.delete();
        for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
            #1;
            if (in_valid && in_ready) c_sent = 1'b1;
            if (Z_valid && Z_ready) got.push_back(Z);
            @(negedge clk);
            if (c_sent) in_valid = 1'b0;
        end
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF,
                32'hAAAA0001 + i);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_dup", Z_valid, 0);

        // Mid-operation reset with a full FIFO
        Z_ready = 1'b0;
        drive_beat(32'h7F800000, 32'h0, 3'd1, 3'd0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("mr_full", in_ready, 0);
        chk("mr_spec_before", spec_count, 2);
        rst_l = 1'b0;
        Z_ready = 1'b1;
        @(negedge clk);
        rst_l = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mr_zvalid", Z_valid, 0);
        chk("mr_outs", {Z, is_special, invalid_op, div_by_zero}, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_spec_count", spec_count, 0);

        // Randomized traffic against the scoreboard
        do_reset();
        q.delete();
        spec_m = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            in_valid = ($urandom % 3) != 0;
            Z_ready = ($urandom % 3) != 0;
            X = $urandom; Y = $urandom; Q_norm = $urandom;
            X_special_case = 3'($urandom_range(0, 7));
            Y_special_case = 3'($urandom_range(0, 7));
            X_one = 1'($urandom % 2);
            #1;
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_zvalid", Z_valid, q.size() != 0);
            chk("rnd_spec_count", spec_count, spec_m);
            if (!Z_valid)
                chk("rnd_idle_outs", {Z, is_special, invalid_op, div_by_zero}, 0);
            if (Z_valid && Z_ready && q.size() != 0) begin
                r = q.pop_front();
                chk("rnd_z", Z, r.z);
                chk("rnd_flags", {is_special, invalid_op, div_by_zero}, {r.sp, r.inv, r.dbz});
            end
            if (in_valid && in_ready) begin
                r = ref_model(X, Y, X_special_case, Y_special_case, Q_norm);
                q.push_back(r);
                if (r.sp && spec_m < 16'hFFFF) spec_m++;
            end
        end

        // spec_count saturation
        do_reset();
        Z_ready = 1'b1;
        drive_beat(32'h7F800000, 32'h3F000000, 3'd1, 3'd0, 1'b0, 32'h0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat_spec_count", spec_count, 16'hFFFF);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
